// File: rtl/pulse_sched_pkg.sv
// pulse_sched shared types: FSM state encoding and round-robin pick helper.
// Imported by the arbiter, the top and the interface users.
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_DELAY,
    PS_ACTIVE,
    PS_DONE
  } pulse_sched_state_t;

  localparam int RR_MAX = 32;
  localparam int RR_IW  = $clog2(RR_MAX);

  typedef logic [RR_IW:0] rr_idx_t;

  // First set bit at or after ptr, wrapping at n; 0 when nothing is set.
  function automatic rr_idx_t rr_pick(
    input logic [RR_MAX-1:0] req,
    input rr_idx_t           ptr,
    input rr_idx_t           n
  );
    rr_idx_t idx;
    logic    found;
    rr_pick = '0;
    found   = 1'b0;
    for (rr_idx_t k = '0; k < rr_idx_t'(RR_MAX); k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (!found && (k < n) && req[idx[RR_IW-1:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/pulse_sched_if.sv
// Requester-side bundle of pulse_sched.
// PULSE_SCHED_ABORT_EN adds the abort/aborted pair.
interface pulse_sched_if #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int WW = 8
);
  localparam int IW = $clog2(N);

  logic [N-1:0]          req;
  logic [N-1:0][DW-1:0]  dly;
  logic [N-1:0][WW-1:0]  wid;
  logic [N-1:0]          grant;
  logic                  busy;
  logic                  pulse_out;
  logic [IW-1:0]         pulse_id;
  logic [N-1:0]          done;
`ifdef PULSE_SCHED_ABORT_EN
  logic                  abort;
  logic                  aborted;

  modport master (
    output req, dly, wid, abort,
    input  grant, busy, pulse_out, pulse_id, done, aborted
  );
  modport slave (
    input  req, dly, wid, abort,
    output grant, busy, pulse_out, pulse_id, done, aborted
  );
`else
  modport master (
    output req, dly, wid,
    input  grant, busy, pulse_out, pulse_id, done
  );
  modport slave (
    input  req, dly, wid,
    output grant, busy, pulse_out, pulse_id, done
  );
`endif

endinterface

// File: rtl/pulse_sched_rr_arbiter.sv
// Combinational round-robin pick among N requesters starting at ptr.
// Returns a one-hot pick (zero when idle) and the chosen index.
module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_pick,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    o_idx  = IW'(rr_pick(RR_MAX'(i_req), rr_idx_t'(i_ptr),
                         rr_idx_t'(N)));
    o_pick = (|i_req) ? (N'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/pulse_sched.sv
// Shared delay/stretch pulse engine, round-robin time-shared by N requesters.
// Define PULSE_SCHED_ABORT_EN to allow cancelling a running sequence.
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int WW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  pulse_sched_if.slave  bus
);
  localparam int IW = $clog2(N);

  pulse_sched_state_t r_state;
  logic [DW-1:0]      r_cnt;
  logic [WW-1:0]      r_wlat;
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_id;
  logic [N-1:0]       r_grant;
  logic [N-1:0]       r_done;
  logic               r_pulse;
  logic [N-1:0]       w_pick;
  logic [IW-1:0]      w_idx;
  logic [N-1:0]       w_id_oh;

  rr_arbiter #(.N(N)) u_arb (
    .i_req  (bus.req),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_idx)
  );

  assign w_id_oh = N'(1) << r_id;

`ifdef PULSE_SCHED_ABORT_EN
  logic r_aborted;
  assign bus.aborted = r_aborted;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PS_IDLE;
      r_cnt   <= '0;
      r_wlat  <= '0;
      r_ptr   <= '0;
      r_id    <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_pulse <= 1'b0;
`ifdef PULSE_SCHED_ABORT_EN
      r_aborted <= 1'b0;
`endif
    end else begin
      r_grant <= '0;
      r_done  <= '0;
`ifdef PULSE_SCHED_ABORT_EN
      r_aborted <= 1'b0;
`endif
      unique case (r_state)
        PS_IDLE: begin
          if (|bus.req) begin
            r_grant <= w_pick;
            r_id    <= w_idx;
            r_cnt   <= bus.dly[w_idx];
            r_wlat  <= (bus.wid[w_idx] == '0) ? WW'(1)
                                              : bus.wid[w_idx];
            r_state <= PS_DELAY;
          end
        end
        PS_DELAY, PS_ACTIVE: begin
`ifdef PULSE_SCHED_ABORT_EN
          if (bus.abort) begin
            r_state   <= PS_DONE;
            r_done    <= w_id_oh;
            r_aborted <= 1'b1;
            r_pulse   <= 1'b0;
          end else
`endif
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - DW'(1);
          end else if (r_state == PS_DELAY) begin
            r_cnt   <= DW'(r_wlat - WW'(1));
            r_pulse <= 1'b1;
            r_state <= PS_ACTIVE;
          end else begin
            r_pulse <= 1'b0;
            r_done  <= w_id_oh;
            r_state <= PS_DONE;
          end
        end
        PS_DONE: begin
          r_ptr   <= (r_id == IW'(N-1)) ? '0 : r_id + IW'(1);
          r_state <= PS_IDLE;
        end
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.done      = r_done;
  assign bus.pulse_out = r_pulse;
  assign bus.pulse_id  = r_id;
  assign bus.busy      = (r_state != PS_IDLE);

endmodule
